// File: rtl/bitonic_pkg.sv
// Shared types and helpers for the bitonic streaming sort controller.
package bitonic_pkg;

  localparam int unsigned MaxValueBits = 256;

  typedef enum logic [0:0] {
    StFill,
    StWaitCredit
  } fill_state_e;

  // Pad value that always sorts to the tail: all-ones for ascending, zero for descending.
  function automatic logic [MaxValueBits-1:0] pad_value(input int unsigned value_bits,
                                                        input int unsigned direction);
    logic [MaxValueBits-1:0] ones;
    ones = {MaxValueBits{1'b1}} >> (MaxValueBits - value_bits);
    return (direction == 0) ? ones : '0;
  endfunction

endpackage

// File: rtl/sort_core.sv
// Fully pipelined bitonic sorting network, one register per compare-exchange stage.
module sort_core #(
  parameter int unsigned VALUE_BITS = 8,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned DIRECTION  = 0
) (
  input  logic                                  clk,
  input  logic [(1<<DEPTH)-1:0][VALUE_BITS-1:0] in_data,
  output logic [(1<<DEPTH)-1:0][VALUE_BITS-1:0] out_data
);

  localparam int unsigned SIZE   = 1 << DEPTH;
  localparam int unsigned NStage = DEPTH * (DEPTH + 1) / 2;

  typedef logic [SIZE-1:0][VALUE_BITS-1:0] vec_t;

  vec_t lvl   [NStage+1];
  vec_t nxt   [NStage];
  vec_t stg_q [NStage];

  always_comb begin
    lvl[0] = in_data;
    for (int s = 0; s < NStage; s++) begin
      lvl[s+1] = stg_q[s];
    end
  end

  // Merge phase p uses block size 2^(p+1); step q compares elements 2^q apart.
  always_comb begin
    int unsigned s;
    int unsigned j;
    logic        up;
    logic [VALUE_BITS-1:0] a, b, lo, hi;
    for (int s0 = 0; s0 < NStage; s0++) begin
      nxt[s0] = '0;
    end
    for (int p = 0; p < DEPTH; p++) begin
      for (int q = p; q >= 0; q--) begin
        s = p * (p + 1) / 2 + (p - q);
        for (int i = 0; i < SIZE; i++) begin
          j  = i ^ (1 << q);
          up = (((i >> (p + 1)) & 1) == 0) ^ (DIRECTION != 0);
          a  = lvl[s][i];
          b  = lvl[s][j];
          lo = (a < b) ? a : b;
          hi = (a < b) ? b : a;
          nxt[s][i] = ((i < j) == up) ? lo : hi;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int s = 0; s < NStage; s++) begin
      stg_q[s] <= nxt[s];
    end
  end

  assign out_data = stg_q[NStage-1];

endmodule

// File: rtl/bitonic_stream_ctrl.sv
// Serial-in/serial-out batch sorter: fills batches, launches them through sort_core
// under a two-credit scheme, and drains results from a ping-pong output buffer.
module bitonic_stream_ctrl
  import bitonic_pkg::*;
#(
  parameter int unsigned VALUE_BITS   = 8,
  parameter int unsigned DEPTH        = 3,
  parameter int unsigned DIRECTION    = 0,
  parameter int unsigned SORT_LATENCY = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [VALUE_BITS-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [VALUE_BITS-1:0] out_data,
  output logic                  out_last
);

  localparam int unsigned SIZE = 1 << DEPTH;
  localparam int unsigned CntW = DEPTH + 1;
  localparam logic [VALUE_BITS-1:0] PadVal = VALUE_BITS'(pad_value(VALUE_BITS, DIRECTION));

  typedef logic [SIZE-1:0][VALUE_BITS-1:0] vec_t;

  fill_state_e     state_q, state_d;
  vec_t            fill_q, fill_d;
  logic [CntW-1:0] fill_cnt_q, fill_cnt_d;
  logic [1:0]      credit_q, credit_d;

  vec_t            cur_vec, launch_vec;
  logic [CntW-1:0] cur_cnt;
  logic            in_hs, out_hs, batch_close, launch, release_buf, credit_ok;

  vec_t            launch_q;
  logic [CntW-1:0] launch_cnt_q;
  logic            launch_vld_q;

  logic [SORT_LATENCY-1:0] sr_vld_q;
  logic [CntW-1:0]         sr_cnt_q [SORT_LATENCY];
  logic                    capture;
  vec_t                    sorted;

  vec_t            buf_data_q [2];
  logic [CntW-1:0] buf_cnt_q  [2];
  logic [1:0]      buf_vld_q;
  logic            wr_ptr_q, rd_ptr_q;
  logic [DEPTH-1:0] rd_idx_q;
  vec_t            rd_vec;

  assign in_ready    = (state_q == StFill) && !rst;
  assign in_hs       = in_valid && in_ready;
  assign out_hs      = out_valid && out_ready;
  assign release_buf = out_hs && out_last;
  // A buffer freed this cycle is already usable: capture is at least two cycles away.
  assign credit_ok   = (credit_q != 2'd0) || release_buf;

  always_comb begin
    cur_vec     = fill_q;
    cur_cnt     = fill_cnt_q;
    batch_close = 1'b0;
    if (in_hs) begin
      cur_vec[fill_cnt_q[DEPTH-1:0]] = in_data;
      cur_cnt     = fill_cnt_q + CntW'(1);
      batch_close = in_last || (fill_cnt_q == CntW'(SIZE - 1));
    end
    for (int i = 0; i < SIZE; i++) begin
      launch_vec[i] = (CntW'(i) < cur_cnt) ? cur_vec[i] : PadVal;
    end
  end

  always_comb begin
    state_d = state_q;
    launch  = 1'b0;
    unique case (state_q)
      StFill: begin
        if (batch_close) begin
          if (credit_ok) launch = 1'b1;
          else           state_d = StWaitCredit;
        end
      end
      StWaitCredit: begin
        if (credit_ok) begin
          launch  = 1'b1;
          state_d = StFill;
        end
      end
      default: state_d = StFill;
    endcase
    fill_d     = cur_vec;
    fill_cnt_d = launch ? '0 : cur_cnt;
  end

  always_comb begin
    credit_d = credit_q;
    if (launch && !release_buf)      credit_d = credit_q - 2'd1;
    else if (!launch && release_buf) credit_d = credit_q + 2'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= StFill;
      fill_cnt_q   <= '0;
      credit_q     <= 2'd2;
      launch_vld_q <= 1'b0;
      sr_vld_q     <= '0;
    end else begin
      state_q      <= state_d;
      fill_cnt_q   <= fill_cnt_d;
      credit_q     <= credit_d;
      launch_vld_q <= launch;
      sr_vld_q[0]  <= launch_vld_q;
      for (int i = 1; i < SORT_LATENCY; i++) begin
        sr_vld_q[i] <= sr_vld_q[i-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    fill_q <= fill_d;
    if (launch) begin
      launch_q     <= launch_vec;
      launch_cnt_q <= cur_cnt;
    end
    sr_cnt_q[0] <= launch_cnt_q;
    for (int i = 1; i < SORT_LATENCY; i++) begin
      sr_cnt_q[i] <= sr_cnt_q[i-1];
    end
  end

  sort_core #(
    .VALUE_BITS(VALUE_BITS),
    .DEPTH     (DEPTH),
    .DIRECTION (DIRECTION)
  ) u_sort_core (
    .clk     (clk),
    .in_data (launch_q),
    .out_data(sorted)
  );

  assign capture = sr_vld_q[SORT_LATENCY-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_vld_q <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      rd_idx_q  <= '0;
    end else begin
      if (capture) begin
        buf_vld_q[wr_ptr_q] <= 1'b1;
        wr_ptr_q            <= ~wr_ptr_q;
      end
      if (out_hs) begin
        if (out_last) begin
          buf_vld_q[rd_ptr_q] <= 1'b0;
          rd_ptr_q            <= ~rd_ptr_q;
          rd_idx_q            <= '0;
        end else begin
          rd_idx_q <= rd_idx_q + DEPTH'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      buf_data_q[wr_ptr_q] <= sorted;
      buf_cnt_q[wr_ptr_q]  <= sr_cnt_q[SORT_LATENCY-1];
    end
  end

  always_comb begin
    rd_vec    = buf_data_q[rd_ptr_q];
    out_valid = buf_vld_q[rd_ptr_q];
    out_last  = out_valid && ((CntW'(rd_idx_q) + CntW'(1)) == buf_cnt_q[rd_ptr_q]);
    out_data  = out_valid ? rd_vec[rd_idx_q] : '0;
  end

endmodule

// File: tb/tb_bitonic_stream_ctrl.sv
// Directed bench for bitonic_stream_ctrl with a queue-based sort model and literal pins.
module tb_bitonic_stream_ctrl;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       in_valid, in_ready, in_last, out_valid, out_ready, out_last;
  logic [7:0] in_data, out_data;
  logic       in_valid2, in_ready2, in_last2, out_valid2, out_last2;
  logic [7:0] in_data2, out_data2;

  bitonic_stream_ctrl #(
    .VALUE_BITS(8), .DEPTH(3), .DIRECTION(0), .SORT_LATENCY(6)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last)
  );

  bitonic_stream_ctrl #(
    .VALUE_BITS(8), .DEPTH(3), .DIRECTION(1), .SORT_LATENCY(6)
  ) dut2 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_data(in_data2), .in_last(in_last2),
    .out_valid(out_valid2), .out_ready(1'b1), .out_data(out_data2), .out_last(out_last2)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  typedef struct {
    logic [7:0] d;
    logic       last;
  } exp_t;

  logic [7:0] cur_q[$];
  exp_t       exp_q[$];
  logic [7:0] got_q[$];
  logic       got_last_q[$];
  logic [7:0] got2_q[$];
  logic       got2_last_q[$];

  // Reference model: collect batches, sort them, compare every output handshake.
  initial begin
    logic       prev_vld, prev_rdy, prev_last;
    logic [7:0] prev_data;
    exp_t       e;
    prev_vld = 1'b0; prev_rdy = 1'b0; prev_last = 1'b0; prev_data = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        cur_q.delete();
        exp_q.delete();
        prev_vld = 1'b0;
      end else begin
        if (prev_vld && !prev_rdy) begin
          chk("hold_valid", out_valid, 1);
          chk("hold_data", out_data, prev_data);
          chk("hold_last", out_last, prev_last);
        end
        if (out_valid && out_ready) begin
          got_q.push_back(out_data);
          got_last_q.push_back(out_last);
          chk("out_expected", int'(exp_q.size() > 0), 1);
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("model_data", out_data, e.d);
            chk("model_last", out_last, e.last);
          end
        end
        if (in_valid && in_ready) begin
          cur_q.push_back(in_data);
          if (in_last || cur_q.size() == 8) begin
            cur_q.sort();
            for (int i = 0; i < cur_q.size(); i++) begin
              e.d    = cur_q[i];
              e.last = (i == cur_q.size() - 1);
              exp_q.push_back(e);
            end
            cur_q.delete();
          end
        end
        prev_vld = out_valid; prev_rdy = out_ready;
        prev_data = out_data; prev_last = out_last;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (!rst && out_valid2) begin
        got2_q.push_back(out_data2);
        got2_last_q.push_back(out_last2);
      end
    end
  end

  // Called just after a rising edge; returns just after the edge that transferred the element.
  task automatic send(input int sel, input logic [7:0] d, input logic last);
    int n;
    logic rdy;
    n = 0;
    if (sel == 0) begin in_valid = 1'b1; in_data = d; in_last = last; end
    else begin in_valid2 = 1'b1; in_data2 = d; in_last2 = last; end
    @(negedge clk);
    rdy = (sel == 0) ? in_ready : in_ready2;
    while (!rdy && n < 300) begin
      @(negedge clk);
      rdy = (sel == 0) ? in_ready : in_ready2;
      n++;
    end
    chk("send_accept", rdy, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; in_valid2 = 1'b0; in_last2 = 1'b0;
  endtask

  task automatic wait_got(input int n);
    int k;
    k = 0;
    while (got_q.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    repeat (12) @(negedge clk);
    chk("drain_count", got_q.size(), n);
    @(posedge clk);
    #1;
  endtask

  int e29[8] = '{0, 1, 2, 3, 5, 7, 9, 255};
  int e30[3] = '{4, 6, 9};
  int b31[8] = '{63, 61, 67, 60, 65, 62, 66, 64};

  initial begin
    int k;
    in_valid = 0; in_last = 0; in_data = 0;
    in_valid2 = 0; in_last2 = 0; in_data2 = 0;
    out_ready = 1'b1;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_in_ready2", in_ready2, 0);
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk); #1;

    // Full ascending batch and latency.
    got_q.delete(); got_last_q.delete();
    send(0, 8'd5, 0); send(0, 8'd3, 0); send(0, 8'd7, 0); send(0, 8'd1, 0);
    send(0, 8'd0, 0); send(0, 8'd255, 0); send(0, 8'd9, 0); send(0, 8'd2, 0);
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (out_valid) break;
    end
    chk("latency", k, 8);
    wait_got(8);
    for (int i = 0; i < 8 && i < got_q.size(); i++) begin
      chk("b29_data", got_q[i], e29[i]);
      chk("b29_last", got_last_q[i], int'(i == 7));
    end

    // Short batch closed by in_last.
    got_q.delete(); got_last_q.delete();
    send(0, 8'd9, 0); send(0, 8'd4, 0); send(0, 8'd6, 1);
    wait_got(3);
    for (int i = 0; i < 3 && i < got_q.size(); i++) begin
      chk("b30_data", got_q[i], e30[i]);
      chk("b30_last", got_last_q[i], int'(i == 2));
    end

    // Backpressure: three batches with output stalled.
    got_q.delete(); got_last_q.delete();
    out_ready = 1'b0;
    for (int b = 1; b <= 3; b++) begin
      for (int i = 0; i < 8; i++) begin
        send(0, 8'(b * 10 + 7 - i), (b == 2 && i == 7));
      end
    end
    @(negedge clk);
    chk("in_ready_full", in_ready, 0);
    repeat (20) @(negedge clk);
    chk("in_ready_still_full", in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    k = 0;
    while (k < 50) begin
      @(negedge clk);
      k++;
      if (out_valid && out_last) break;
    end
    chk("wait_release_in_ready", in_ready, 0);
    @(negedge clk);
    chk("release_in_ready", in_ready, 1);
    chk("release_credit", dut.credit_q, 0);
    @(posedge clk); #1;
    wait_got(24);
    for (int i = 0; i < 24 && i < got_q.size(); i++) begin
      chk("b31_data", got_q[i], (i / 8 + 1) * 10 + i % 8);
      chk("b31_last", got_last_q[i], int'(i % 8 == 7));
    end

    // Reset in the middle of a drain.
    got_q.delete(); got_last_q.delete();
    for (int i = 0; i < 8; i++) send(0, 8'(b31[i]), 0);
    k = 0;
    while (got_q.size() < 3 && k < 50) begin
      @(negedge clk);
      k++;
    end
    @(posedge clk); #2;
    chk("pre_reset_valid", out_valid, 1);
    #1; rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_data", out_data, 0);
    chk("mid_rst_out_last", out_last, 0);
    chk("mid_rst_in_ready", in_ready, 0);
    repeat (2) @(negedge clk);
    @(posedge clk); #1; rst = 1'b0;
    got_q.delete(); got_last_q.delete();
    send(0, 8'd8, 0); send(0, 8'd8, 0); send(0, 8'd1, 1);
    wait_got(3);
    if (got_q.size() == 3) begin
      chk("b33_d0", got_q[0], 1);
      chk("b33_d1", got_q[1], 8);
      chk("b33_d2", got_q[2], 8);
      chk("b33_last", got_last_q[2], 1);
    end

    // Descending instance: pad zero must not be emitted.
    got2_q.delete(); got2_last_q.delete();
    send(1, 8'd3, 0); send(1, 8'd200, 1);
    k = 0;
    while (got2_q.size() < 2 && k < 50) begin
      @(negedge clk);
      k++;
    end
    repeat (12) @(negedge clk);
    chk("b34_count", got2_q.size(), 2);
    if (got2_q.size() == 2) begin
      chk("b34_d0", got2_q[0], 200);
      chk("b34_d1", got2_q[1], 3);
      chk("b34_last0", got2_last_q[0], 0);
      chk("b34_last1", got2_last_q[1], 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not complete, %0d of %0d checks passed", n_pass, n_checks);
    $fatal(1);
  end

endmodule
